opt_win_avg: RTL and testbench

Streaming moving-average stage that sits directly downstream of the addressed data generator and consumes its `o_data` word stream. It keeps the last 2^WIN_LOG2 accepted samples in a circular buffer and maintains a running sum. Once the window is full, it outputs the window sum and the truncated average one cycle after each accepted sample.

---
 rtl/opt_pkg.sv | 20 ++
 rtl/opt_win_buf.sv | 38 +++
 rtl/opt_win_avg.sv | 88 ++++++++
 tb/tb_opt_win_avg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/opt_pkg.sv
// Shared types and defaults for the moving-average stage.
// Defaults match the upstream data generator word.
package opt_pkg;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_WIN_LOG2   = 2;

  function automatic int sum_width(
    input int dw,
    input int wl
  );
    return dw + wl;
  endfunction

endpackage

// File: rtl/opt_win_buf.sv
// Circular sample buffer with combinational read of the slot
// about to be overwritten (read-before-write).
module opt_win_buf
  import opt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WIN_LOG2   = DEF_WIN_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] old
);

  localparam int DEPTH = 1 << WIN_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [WIN_LOG2-1:0]   wr_ptr;

  assign old = mem[wr_ptr];

  // Zeroed slots make the fill-phase subtraction a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/opt_win_avg.sv
// Streaming moving average over the last 2^WIN_LOG2 samples.
// Emits window sum and truncated average once the window is full.
module opt_win_avg
  import opt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WIN_LOG2   = DEF_WIN_LOG2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data,
  input  logic                           i_clear,
  output logic                           o_valid,
  output logic [DATA_WIDTH+WIN_LOG2-1:0] o_sum,
  output logic [DATA_WIDTH-1:0]          o_avg,
  output logic                           o_primed
);

  localparam int SW    = sum_width(DATA_WIDTH, WIN_LOG2);
  localparam int CW    = WIN_LOG2 + 1;
  localparam int DEPTH = 1 << WIN_LOG2;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [SW-1:0]       sum, sum_n;
  logic [DATA_WIDTH-1:0] old;
  logic                accept;
  logic                emit;

  assign accept = i_valid & ~i_clear;
  assign emit   = accept & (state_n == ST_RUN);

  opt_win_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .WIN_LOG2  (WIN_LOG2)
  ) u_buf (
    .clk  (i_clk),
    .rst  (i_rst),
    .clear(i_clear),
    .we   (accept),
    .wdata(i_data),
    .old  (old)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sum_n   = sum;
    if (i_clear) begin
      state_n = ST_FILL;
      cnt_n   = '0;
      sum_n   = '0;
    end else if (i_valid) begin
      sum_n = sum + SW'(i_data) - SW'(old);
      if (state == ST_FILL) begin
        cnt_n = cnt + 1'b1;
        if (cnt_n == CW'(DEPTH)) state_n = ST_RUN;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_FILL;
      cnt      <= '0;
      sum      <= '0;
      o_valid  <= 1'b0;
      o_sum    <= '0;
      o_avg    <= '0;
      o_primed <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sum      <= sum_n;
      o_valid  <= emit;
      o_primed <= (state_n == ST_RUN);
      if (i_clear) begin
        o_sum <= '0;
        o_avg <= '0;
      end else if (emit) begin
        o_sum <= sum_n;
        o_avg <= sum_n[SW-1:WIN_LOG2];
      end
    end
  end

endmodule

// File: tb/tb_opt_win_avg.sv
// Directed self-checking bench for opt_win_avg (defaults 8/2).
// Inputs driven and outputs sampled on the falling edge.
module tb_opt_win_avg;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_clear = 1'b0;
  logic        o_valid;
  logic [9:0]  o_sum;
  logic [7:0]  o_avg;
  logic        o_primed;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  opt_win_avg dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_clear (i_clear),
    .o_valid (o_valid),
    .o_sum   (o_sum),
    .o_avg   (o_avg),
    .o_primed(o_primed)
  );

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    i_valid = v;
    i_data  = d;
    i_clear = c;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b want 0", o_valid);
    end
    checks++;
    if (o_sum !== 10'd0) begin
      errors++; $display("FAIL reset_sum got %0d want 0", o_sum);
    end
    checks++;
    if (o_avg !== 8'd0) begin
      errors++; $display("FAIL reset_avg got %0d want 0", o_avg);
    end
    checks++;
    if (o_primed !== 1'b0) begin
      errors++; $display("FAIL reset_primed got %0b want 0", o_primed);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_fill();
    logic [7:0] s [3];
    s[0] = 8'd4; s[1] = 8'd8; s[2] = 8'd12;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, s[i], 1'b0);
      checks++;
      if (o_valid !== 1'b0 || o_primed !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d valid=%0b primed=%0b want 0/0", i, o_valid, o_primed);
      end
    end
    step(1'b1, 8'd16, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_primed !== 1'b1) begin
      errors++;
      $display("FAIL first_flags valid=%0b primed=%0b want 1/1", o_valid, o_primed);
    end
    checks++;
    if (o_sum !== 10'd40 || o_avg !== 8'd10) begin
      errors++;
      $display("FAIL first_result sum=%0d avg=%0d want 40/10", o_sum, o_avg);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 8'd20, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 10'd56 || o_avg !== 8'd14) begin
      errors++;
      $display("FAIL wrap_20 valid=%0b sum=%0d avg=%0d want 1/56/14", o_valid, o_sum, o_avg);
    end
    step(1'b1, 8'd24, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 10'd72 || o_avg !== 8'd18) begin
      errors++;
      $display("FAIL wrap_24 valid=%0b sum=%0d avg=%0d want 1/72/18", o_valid, o_sum, o_avg);
    end
  endtask

  task automatic test_max();
    step(1'b0, 8'd0, 1'b1);
    checks++;
    if (o_primed !== 1'b0 || o_sum !== 10'd0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL max_clear primed=%0b sum=%0d valid=%0b want 0/0/0", o_primed, o_sum, o_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd255, 1'b0);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL max_fill_%0d valid=%0b want 0", i, o_valid);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'd255, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_sum !== 10'd1020 || o_avg !== 8'd255) begin
        errors++;
        $display("FAIL max_%0d valid=%0b sum=%0d avg=%0d want 1/1020/255", i, o_valid, o_sum, o_avg);
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] s [4];
    s[0] = 8'd1; s[1] = 8'd2; s[2] = 8'd3; s[3] = 8'd3;
    step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, s[i], 1'b0);
      step(1'b0, 8'd77, 1'b0);
      checks++;
      if (o_valid !== 1'b0 || o_primed !== 1'b0 || o_sum !== 10'd0) begin
        errors++;
        $display("FAIL gap_idle_%0d valid=%0b primed=%0b sum=%0d want 0/0/0",
                 i, o_valid, o_primed, o_sum);
      end
    end
    step(1'b1, s[3], 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 10'd9 || o_avg !== 8'd2) begin
      errors++;
      $display("FAIL gap_result valid=%0b sum=%0d avg=%0d want 1/9/2", o_valid, o_sum, o_avg);
    end
    step(1'b0, 8'd50, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_sum !== 10'd9 || o_primed !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold valid=%0b sum=%0d primed=%0b want 0/9/1", o_valid, o_sum, o_primed);
    end
  endtask

  task automatic test_clear_collision();
    step(1'b1, 8'd99, 1'b1);
    checks++;
    if (o_primed !== 1'b0 || o_sum !== 10'd0 || o_avg !== 8'd0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide primed=%0b sum=%0d avg=%0d valid=%0b want 0/0/0/0",
               o_primed, o_sum, o_avg, o_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd1, 1'b0);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL collide_fill_%0d valid=%0b want 0", i, o_valid);
      end
    end
    step(1'b1, 8'd1, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 10'd4 || o_avg !== 8'd1) begin
      errors++;
      $display("FAIL collide_refill valid=%0b sum=%0d avg=%0d want 1/4/1", o_valid, o_sum, o_avg);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 8'd5, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 10'd8) begin
      errors++;
      $display("FAIL pre_reset valid=%0b sum=%0d want 1/8", o_valid, o_sum);
    end
    i_valid = 1'b1;
    i_data  = 8'd5;
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_sum !== 10'd0 || o_avg !== 8'd0 || o_primed !== 1'b0) begin
      errors++;
      $display("FAIL async_reset valid=%0b sum=%0d avg=%0d primed=%0b want 0/0/0/0",
               o_valid, o_sum, o_avg, o_primed);
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd7, 1'b0);
      checks++;
      if (o_valid !== 1'b0 || o_primed !== 1'b0) begin
        errors++;
        $display("FAIL refill_%0d valid=%0b primed=%0b want 0/0", i, o_valid, o_primed);
      end
    end
    step(1'b1, 8'd7, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 10'd28 || o_avg !== 8'd7) begin
      errors++;
      $display("FAIL refill_result valid=%0b sum=%0d avg=%0d want 1/28/7", o_valid, o_sum, o_avg);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_max();
    test_gap();
    test_clear_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
